mem_port_arb: RTL and testbench

//   Shares the single unified RAM port between the IF stage (instruction fetch) and MEM stage (load/store).

---
 rtl/mem_port_arb_if.sv | 62 ++++++
 rtl/mem_port_arb.sv | 156 +++++++++++++++
 tb/tb_mem_port_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_if.sv
// -----------------------------------------------------------------------------
// mem_port_arb_if
//   Bundles the fetch port, the load/store port, the stall outputs and the
//   shared RAM command/response port of mem_port_arb.
//
//   Modports:
//     slave  - the arbiter: takes requests and RAM responses, drives acks,
//              read data, stalls, RAM commands and bus_err.
//     master - the environment (pipeline stages plus RAM): the reverse view.
//
//   Signals:
//     if_req/if_addr -> if_rdata/if_ack        instruction fetch
//     mem_req/mem_we/mem_addr/mem_wdata
//                    -> mem_rdata/mem_ack      load/store
//     stall_if, stall_mem                      to hazard unit
//     ram_req/ram_we/ram_addr/ram_wdata        RAM command (registered)
//     ram_ready, ram_valid, ram_rdata          RAM handshake / response
//     bus_err                                  response timeout pulse
// -----------------------------------------------------------------------------
interface mem_port_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          stall_if;
    logic          stall_mem;

    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ready;
    logic          ram_valid;
    logic [DW-1:0] ram_rdata;

    logic          bus_err;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
               ram_ready, ram_valid, ram_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
               ram_req, ram_we, ram_addr, ram_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
               ram_ready, ram_valid, ram_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
               ram_req, ram_we, ram_addr, ram_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arb.sv
// -----------------------------------------------------------------------------
// mem_port_arb
//   Shares one RAM port between the IF stage (fetch) and the MEM stage
//   (load/store). Each access runs IDLE -> REQ -> RESP -> IDLE. Under
//   contention the grant alternates so neither stage starves.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - mem_port_arb_if.slave (fetch, load/store, stalls, RAM port)
//
//   Parameters: AW address width, DW data width, TIMEOUT response watchdog
//   limit in RESP cycles.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to enable the response
//   watchdog (bus_err pulse plus forced ack with zero data). Without it
//   bus_err is tied 0 and RESP waits indefinitely.
// -----------------------------------------------------------------------------
module mem_port_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_port_arb_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic [1:0] {G_NONE, G_IF, G_MEM}   grant_t;

    state_t        state_q, state_d;
    grant_t        grant_q, grant_d;
    grant_t        last_grant_q, last_grant_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter holds the number of RESP cycles already spent waiting, so the
    // TIMEOUT-th waiting cycle is the one that sees TIMEOUT-1.
    assign timeout = (state_q == S_RESP) && !bus.ram_valid &&
                     (tmo_cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_RESP && !bus.ram_valid)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT > 0);
    assign timeout              = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= G_NONE;
            last_grant_q <= G_IF;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ram_req_q    <= ram_req_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // Next-state logic; command registers only load on REQ entry, so they
    // stay stable through REQ and RESP.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ram_req_d    = ram_req_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    // MEM wins a tie unless it won the previous grant.
                    if (bus.mem_req && (!bus.if_req || last_grant_q != G_MEM)) begin
                        grant_d      = G_MEM;
                        last_grant_d = G_MEM;
                        ram_we_d     = bus.mem_we;
                        ram_addr_d   = bus.mem_addr;
                        ram_wdata_d  = bus.mem_wdata;
                    end else begin
                        grant_d      = G_IF;
                        last_grant_d = G_IF;
                        ram_we_d     = 1'b0;
                        ram_addr_d   = bus.if_addr;
                        ram_wdata_d  = '0;
                    end
                    ram_req_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.ram_ready) begin
                    ram_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.ram_valid || timeout) begin
                    grant_d = G_NONE;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs. A requester that dropped its req mid-access (flush) gets no ack.
    logic          done;
    logic          if_ack_c, mem_ack_c;
    logic [DW-1:0] rdata_c;

    always_comb begin
        done      = (state_q == S_RESP) && (bus.ram_valid || timeout);
        if_ack_c  = done && (grant_q == G_IF)  && bus.if_req;
        mem_ack_c = done && (grant_q == G_MEM) && bus.mem_req;
        rdata_c   = timeout ? '0 : bus.ram_rdata;
    end

    assign bus.if_ack    = if_ack_c;
    assign bus.mem_ack   = mem_ack_c;
    assign bus.if_rdata  = rdata_c;
    assign bus.mem_rdata = rdata_c;
    assign bus.stall_if  = bus.if_req  & ~if_ack_c;
    assign bus.stall_mem = bus.mem_req & ~mem_ack_c;
    assign bus.ram_req   = ram_req_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.bus_err   = timeout;
endmodule

// File: tb/tb_mem_port_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arb
//   Directed bench for mem_port_arb. Inputs change 1 time unit after the
//   rising edge; outputs are checked on the falling edge. Define
//   MEM_ARB_TIMEOUT_EN for both design and bench to cover the watchdog.
// -----------------------------------------------------------------------------
module tb_mem_port_arb;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arb_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arb #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.ram_ready = 1'b0;
        bus.ram_valid = 1'b0;
        bus.ram_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h0 || bus.ram_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ram_regs: got req=%b we=%b addr=%h wdata=%h, expected all 0", bus.ram_req, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        n_checks++;
        if (bus.if_ack !== 1'b0 || bus.mem_ack !== 1'b0 || bus.bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got if_ack=%b mem_ack=%b bus_err=%b, expected 0", bus.if_ack, bus.mem_ack, bus.bus_err);
        end
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_req: got ram_req=%b, expected 1", bus.ram_req);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ram_req !== 1'b0 || bus.ram_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async_drop: got ram_req=%b addr=%h, expected 0/0", bus.ram_req, bus.ram_addr);
        end
        tick();
        bus.if_req    = 1'b0;
        bus.ram_valid = 1'b1;   // stray response must not produce an ack
        rst_n         = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ram_req !== 1'b0 || bus.if_ack !== 1'b0 || bus.mem_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_after_release: cycle %0d got req=%b if_ack=%b mem_ack=%b, expected 0", c, bus.ram_req, bus.if_ack, bus.mem_ack);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_single_fetch();
        logic exp_ack;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h100;
        bus.ram_ready = 1'b1;
        bus.ram_valid = 1'b1;
        bus.ram_rdata = 32'hDEADBEEF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            exp_ack = (c == 3);
            n_checks++;
            if (bus.if_ack !== exp_ack || bus.stall_if !== !exp_ack) begin
                n_fail++;
                $display("FAIL fetch_ack_stall: cycle %0d got ack=%b stall=%b, expected ack=%b stall=%b", c, bus.if_ack, bus.stall_if, exp_ack, !exp_ack);
            end
            if (c == 2) begin
                n_checks++;
                if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h100 || bus.ram_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_cmd: got req=%b addr=%h we=%b, expected 1/00000100/0", bus.ram_req, bus.ram_addr, bus.ram_we);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (bus.if_rdata !== 32'hDEADBEEF || bus.ram_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_data: got rdata=%h ram_req=%b, expected deadbeef/0", bus.if_rdata, bus.ram_req);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        logic exp_if, exp_mem;
        apply_reset();
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h200;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = 32'h300;
        bus.ram_ready = 1'b1;
        bus.ram_valid = 1'b1;
        bus.ram_rdata = 32'h12345678;
        // Each transaction takes 3 cycles; expected order MEM, IF, MEM, IF.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_mem = (c % 3 == 2) && ((c / 3) % 2 == 0);
            exp_if  = (c % 3 == 2) && ((c / 3) % 2 == 1);
            n_checks++;
            if (bus.if_ack !== exp_if || bus.mem_ack !== exp_mem) begin
                n_fail++;
                $display("FAIL contention_ack: cycle %0d got if=%b mem=%b, expected if=%b mem=%b", c, bus.if_ack, bus.mem_ack, exp_if, exp_mem);
            end
            n_checks++;
            if (bus.stall_if !== !exp_if || bus.stall_mem !== !exp_mem) begin
                n_fail++;
                $display("FAIL contention_stall: cycle %0d got sif=%b smem=%b, expected sif=%b smem=%b", c, bus.stall_if, bus.stall_mem, !exp_if, !exp_mem);
            end
            if (c % 3 == 1) begin
                n_checks++;
                if (bus.ram_addr !== (((c / 3) % 2 == 0) ? 32'h300 : 32'h200)) begin
                    n_fail++;
                    $display("FAIL contention_addr: cycle %0d got %h, expected %h", c, bus.ram_addr, (((c / 3) % 2 == 0) ? 32'h300 : 32'h200));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_store_flush();
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h20;
        bus.mem_wdata = 32'h5A;
        bus.ram_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h20 || bus.ram_wdata !== 32'h5A) begin
            n_fail++;
            $display("FAIL store_cmd: got req=%b we=%b addr=%h wdata=%h, expected 1/1/20/5a", bus.ram_req, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        tick();
        bus.mem_req   = 1'b0;
        bus.ram_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.mem_ack !== 1'b0 || bus.stall_mem !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_ack: got mem_ack=%b stall_mem=%b, expected 0/0", bus.mem_ack, bus.stall_mem);
        end
        tick();
        bus.ram_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h40;
        @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got ram_req=%b, expected 0", bus.ram_req);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h40 || bus.ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_next_cmd: got req=%b addr=%h we=%b, expected 1/40/0", bus.ram_req, bus.ram_addr, bus.ram_we);
        end
        tick();
        bus.ram_valid = 1'b1;
        bus.ram_rdata = 32'hCAFE0001;
        @(negedge clk);
        n_checks++;
        if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL flush_next_ack: got ack=%b rdata=%h, expected 1/cafe0001", bus.if_ack, bus.if_rdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_ready_wait();
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h80;
        bus.ram_valid = 1'b1;   // ignored while not in RESP
        bus.ram_rdata = 32'h0BADF00D;
        @(negedge clk);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h80 || bus.if_ack !== 1'b0 || bus.stall_if !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_wait: wait %0d got req=%b addr=%h ack=%b stall=%b, expected 1/80/0/1", k, bus.ram_req, bus.ram_addr, bus.if_ack, bus.stall_if);
            end
            tick();
        end
        bus.ram_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b1 || bus.if_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_accept: got req=%b ack=%b, expected 1/0", bus.ram_req, bus.if_ack);
        end
        tick();
        bus.ram_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ram_req !== 1'b0 || bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL ready_resp: got req=%b ack=%b rdata=%h, expected 0/1/0badf00d", bus.ram_req, bus.if_ack, bus.if_rdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic exp_err;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = 32'h10;
        bus.ram_ready = 1'b1;
        bus.ram_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            exp_err = (k == TMO);
            n_checks++;
            if (bus.bus_err !== exp_err || bus.mem_ack !== exp_err) begin
                n_fail++;
                $display("FAIL timeout_pulse: resp cycle %0d got err=%b ack=%b, expected %b/%b", k, bus.bus_err, bus.mem_ack, exp_err, exp_err);
            end
            if (k == TMO) begin
                n_checks++;
                if (bus.mem_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL timeout_rdata: got %h, expected 00000000", bus.mem_rdata);
                end
            end
            tick();
        end
`else
        for (int k = 1; k <= TMO + 4; k++) begin
            @(negedge clk);
            exp_err = 1'b0;
            n_checks++;
            if (bus.bus_err !== exp_err || bus.mem_ack !== 1'b0 || bus.stall_mem !== 1'b1) begin
                n_fail++;
                $display("FAIL resp_wait: resp cycle %0d got err=%b ack=%b stall=%b, expected 0/0/1", k, bus.bus_err, bus.mem_ack, bus.stall_mem);
            end
            tick();
        end
        bus.ram_valid = 1'b1;
        bus.ram_rdata = 32'h00000055;
        @(negedge clk);
        n_checks++;
        if (bus.mem_ack !== 1'b1 || bus.mem_rdata !== 32'h55) begin
            n_fail++;
            $display("FAIL resp_late_ack: got ack=%b rdata=%h, expected 1/00000055", bus.mem_ack, bus.mem_rdata);
        end
        tick();
`endif
        bus.mem_req   = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h60;
        bus.ram_valid = 1'b1;   // late response arriving in IDLE
        bus.ram_rdata = 32'h77;
        @(negedge clk);
        n_checks++;
        if (bus.if_ack !== 1'b0 || bus.bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_idle: got ack=%b err=%b, expected 0/0", bus.if_ack, bus.bus_err);
        end
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h77) begin
            n_fail++;
            $display("FAIL after_fetch: got ack=%b rdata=%h, expected 1/00000077", bus.if_ack, bus.if_rdata);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store_flush();
        test_ready_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
